pipe_field: RTL and testbench
=============================

Name: pipe_field

Overview:
Parametrised obstacle manager for the flappy-bird game: owns NUM_PIPES pipe positions, scrolls them left at a score-dependent speed, recycles off-screen pipes with fresh random gap heights, and counts each passed pipe exactly once. Sits between the game-state FSM and the renderer/collision logic. Runs on the single system clock and advances once per frame_tick strobe.

Parameters:
NUM_PIPES, 4, number of pipe instances (2..8)
COORD_W, 11, signed coordinate width (x may go negative)
PIPE_W, 78, pipe width in pixels
SEPARATION, 250, horizontal pitch between consecutive pipes
START_X, 700, x of pipe 0 on reload
Y_CENTRE, 146, base gap y
Y_RAND_BITS, 6, random y offset width (0..2^Y_RAND_BITS-1)
SCORE_W, 16, score counter width
LEVEL_STEP, 8, points per speed increment
SPEED_MAX, 4, maximum pixels per frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-clk strobe per video frame
game_state  in  4  one-hot: 0001 START_SCREEN, 0010 IN_GAME, 0100 PAUSE, 1000 END_SCREEN
bird_x  in  COORD_W  bird left edge (unsigned, < 2^(COORD_W-1))
pipe_x  out  NUM_PIPES*COORD_W  signed x per pipe, pipe i at [i*COORD_W +: COORD_W]
pipe_y  out  NUM_PIPES*COORD_W  gap y per pipe, same packing
score  out  SCORE_W  passed-pipe count
speed  out  3  current scroll speed, 1..SPEED_MAX
score_pulse  out  1  one-clk pulse on any score increment

Behaviour:
- All outputs registered; state changes only on the clk edge where frame_tick=1 (except LFSR and rst). Effect visible 1 clk after the strobe.
- Reset (rst=1 at clk edge): pipe_x[i]=START_X+i*SEPARATION, pipe_y[i]=Y_CENTRE, passed[i]=0, score=0, speed=1, score_pulse=0, LFSR=16'hACE1. rst mid-frame overrides a simultaneous frame_tick.
- LFSR: 16-bit maximal Fibonacci (taps 16,14,13,11), steps every clk, never zero. Pipe i's offset = Y_RAND_BITS bits of LFSR rotated left by 3*i, low bits.
- game_state on frame_tick:
  START_SCREEN: reload as reset but pipe_y[i]=Y_CENTRE+offset_i; score=0, speed=1.
  IN_GAME: move/recycle/score (below).
  PAUSE, END_SCREEN, any non-one-hot value: hold all state; score_pulse=0.
- Move: x_next[i]=pipe_x[i]-speed (signed COORD_W arithmetic).
- Recycle: if x_next[i]+PIPE_W <= 0 then pipe_x[i] = x_next[(i+NUM_PIPES-1)%NUM_PIPES] + SEPARATION, pipe_y[i]=Y_CENTRE+offset_i, passed[i]=0. Uses predecessor's post-move value so pitch stays exactly SEPARATION at any speed. Two pipes never recycle in the same frame (SEPARATION > PIPE_W guaranteed by parameter check).
- Score: pipe i scores when passed[i]=0 and x_next[i]+PIPE_W < bird_x; sets passed[i]=1. score += number of pipes scoring this frame; saturates at 2^SCORE_W-1 (no wrap). score_pulse=1 for that clk iff ≥1 pipe scored. A recycled pipe cannot score in its recycle frame.
- Speed: computed combinationally from registered score, registered with it: speed = 1 + min(score/LEVEL_STEP, SPEED_MAX-1). LEVEL_STEP a power of two (shift, no divider).
- Elaboration error if NUM_PIPES<2, SEPARATION<=PIPE_W, or SPEED_MAX>7.

Decomposition:
- Shared package game_pkg: game_state one-hot localparams (START_SCREEN, IN_GAME, PAUSE, END_SCREEN), screen/play-area constants (Y_CENTRE derivation (420-128)/2).
- Sub-module lfsr16 (clk, rst, seed-on-reset, 16-bit state out); reusable by other game blocks.

Test Plan:
- rst then hold -> pipe_x = 700,950,1200,1450; pipe_y all 146; score 0; speed 1.
- IN_GAME, 10 frame_ticks -> pipe_x[0]=690; ticks without frame_tick leave x unchanged.
- Drive pipe 0 to x=-77 at speed 1, next tick -> pipe_x[0]=pipe_x[3]_new+250, pipe_y[0] in 146..209, passed cleared.
- bird_x=100, pipe 0 crosses x+78<100 -> score 0→1, single score_pulse; further frames no re-score until recycle.
- Score reaches 8 -> speed 2 next frame; reaches 24 -> speed 4; 40 -> stays 4. Force score 65535 + pass -> stays 65535.
- PAUSE for 50 ticks -> all outputs frozen; START_SCREEN tick -> reload, score 0; rst asserted with frame_tick in IN_GAME -> reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: one-hot game states, play-area geometry, LFSR seed and helpers.
// Pure declarations; no timing or flow control of its own.
package game_pkg;

  localparam logic [3:0] START_SCREEN = 4'b0001;
  localparam logic [3:0] IN_GAME      = 4'b0010;
  localparam logic [3:0] PAUSE        = 4'b0100;
  localparam logic [3:0] END_SCREEN   = 4'b1000;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int PLAY_H       = 420;
  localparam int GAP_H        = 128;
  localparam int Y_CENTRE_DEF = (PLAY_H - GAP_H) / 2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_RELOAD,
    ACT_PLAY
  } frame_act_e;

  // Rotate left by k (0..15) and keep the low 'bits' bits.
  function automatic logic [15:0] lfsr_offset(logic [15:0] s, int unsigned k, int unsigned bits);
    logic [15:0] rot;
    rot = (s << k) | (s >> (16 - k));
    return rot & ((16'h1 << bits) - 16'h1);
  endfunction

endpackage

// File: rtl/pipe_field_if.sv
// Bundle between the game FSM (master) and the pipe field (slave).
// Level/strobe signals only; the pipe field never stalls its master.
interface pipe_field_if #(
  parameter int NUM_PIPES = 4,
  parameter int COORD_W   = 11,
  parameter int SCORE_W   = 16
);
  logic                         frame_tick;
  logic [3:0]                   game_state;
  logic [COORD_W-1:0]           bird_x;
  logic [NUM_PIPES*COORD_W-1:0] pipe_x;
  logic [NUM_PIPES*COORD_W-1:0] pipe_y;
  logic [SCORE_W-1:0]           score;
  logic [2:0]                   speed;
  logic                         score_pulse;

  modport master (
    output frame_tick, game_state, bird_x,
    input  pipe_x, pipe_y, score, speed, score_pulse
  );

  modport slave (
    input  frame_tick, game_state, bird_x,
    output pipe_x, pipe_y, score, speed, score_pulse
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit maximal Fibonacci LFSR (taps 16,14,13,11), steps every clk, loads SEED on rst.
// State visible one clk after each edge; free running, no stall input.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state_o
);
  logic [15:0] state_q, state_d;

  if (SEED == 16'h0000) begin : g_bad_seed
    $error("lfsr16: an all-zero seed locks the register");
  end

  always_comb begin
    state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/pipe_field.sv
// Obstacle manager: scrolls, recycles and scores NUM_PIPES pipes once per frame_tick.
// All outputs registered, updated 1 clk after the strobe; never back-pressures the FSM.
module pipe_field
  import game_pkg::*;
#(
  parameter int NUM_PIPES   = 4,
  parameter int COORD_W     = 11,
  parameter int PIPE_W      = 78,
  parameter int SEPARATION  = 250,
  parameter int START_X     = 700,
  parameter int Y_CENTRE    = Y_CENTRE_DEF,
  parameter int Y_RAND_BITS = 6,
  parameter int SCORE_W     = 16,
  parameter int LEVEL_STEP  = 8,
  parameter int SPEED_MAX   = 4
) (
  input  logic        clk,
  input  logic        rst,
  pipe_field_if.slave bus
);

  if (NUM_PIPES < 2) begin : g_bad_pipes
    $error("pipe_field: NUM_PIPES must be at least 2");
  end
  if (SEPARATION <= PIPE_W) begin : g_bad_sep
    $error("pipe_field: SEPARATION must exceed PIPE_W");
  end
  if (SPEED_MAX < 1 || SPEED_MAX > 7) begin : g_bad_speed
    $error("pipe_field: SPEED_MAX must be 1..7");
  end
  if (LEVEL_STEP < 1 || (LEVEL_STEP & (LEVEL_STEP - 1)) != 0) begin : g_bad_level
    $error("pipe_field: LEVEL_STEP must be a power of two");
  end

  localparam int XW     = COORD_W + 2;
  localparam int HIT_W  = $clog2(NUM_PIPES + 1);
  localparam int SW1    = SCORE_W + 1;
  localparam int LVL_SH = $clog2(LEVEL_STEP);

  typedef logic signed [XW-1:0] xw_t;
  typedef logic [COORD_W-1:0]   coord_t;

  localparam xw_t    PIPE_W_X = xw_t'(PIPE_W);
  localparam xw_t    SEP_X    = xw_t'(SEPARATION);
  // The rightmost reload position can exceed the signed COORD_W range, so x is
  // decoded as a window: only the last PIPE_W+SPEED_MAX codes read as negative.
  localparam coord_t NEG_EDGE = coord_t'((1 << COORD_W) - PIPE_W - SPEED_MAX);

  function automatic xw_t decode_x(coord_t raw);
    return (raw >= NEG_EDGE) ? $signed({2'b11, raw}) : $signed({2'b00, raw});
  endfunction

  function automatic logic [2:0] speed_of(logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] lvl;
    lvl = s >> LVL_SH;
    if (lvl >= SCORE_W'(SPEED_MAX - 1)) return 3'(SPEED_MAX);
    return 3'(lvl) + 3'd1;
  endfunction

  coord_t               x_q [NUM_PIPES];
  coord_t               x_d [NUM_PIPES];
  coord_t               y_q [NUM_PIPES];
  coord_t               y_d [NUM_PIPES];
  logic [NUM_PIPES-1:0] passed_q, passed_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           speed_q, speed_d;
  logic                 pulse_q, pulse_d;

  logic [15:0]          lfsr;
  xw_t                  x_next [NUM_PIPES];
  coord_t               gap_y  [NUM_PIPES];
  logic [HIT_W-1:0]     hits;
  logic [SW1-1:0]       score_sum;
  frame_act_e           act;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr)
  );

  always_comb begin
    act = ACT_HOLD;
    if (bus.frame_tick) begin
      case (bus.game_state)
        START_SCREEN: act = ACT_RELOAD;
        IN_GAME:      act = ACT_PLAY;
        default:      act = ACT_HOLD;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      x_next[i] = decode_x(x_q[i]) - $signed({{(XW-3){1'b0}}, speed_q});
      gap_y[i]  = coord_t'(Y_CENTRE) + coord_t'(lfsr_offset(lfsr, (3 * i) % 16, Y_RAND_BITS));
    end
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    passed_d  = passed_q;
    score_d   = score_q;
    speed_d   = speed_q;
    pulse_d   = 1'b0;
    hits      = '0;
    score_sum = '0;
    case (act)
      ACT_RELOAD: begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          x_d[i] = coord_t'(START_X + i * SEPARATION);
          y_d[i] = gap_y[i];
        end
        passed_d = '0;
        score_d  = '0;
        speed_d  = 3'd1;
      end
      ACT_PLAY: begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          if (x_next[i] + PIPE_W_X <= xw_t'(0)) begin
            // Respawn behind the predecessor's already-moved position to keep the pitch exact.
            x_d[i]      = coord_t'(x_next[(i + NUM_PIPES - 1) % NUM_PIPES] + SEP_X);
            y_d[i]      = gap_y[i];
            passed_d[i] = 1'b0;
          end else begin
            x_d[i] = coord_t'(x_next[i]);
            if (!passed_q[i] && (x_next[i] + PIPE_W_X < $signed({2'b00, bus.bird_x}))) begin
              passed_d[i] = 1'b1;
              hits        = hits + HIT_W'(1);
            end
          end
        end
        score_sum = {1'b0, score_q} + SW1'(hits);
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        pulse_d   = (hits != '0);
        speed_d   = speed_of(score_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= coord_t'(START_X + i * SEPARATION);
        y_q[i] <= coord_t'(Y_CENTRE);
      end
      passed_q <= '0;
      score_q  <= '0;
      speed_q  <= 3'd1;
      pulse_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      passed_q <= passed_d;
      score_q  <= score_d;
      speed_q  <= speed_d;
      pulse_q  <= pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_out
    assign bus.pipe_x[g*COORD_W +: COORD_W] = x_q[g];
    assign bus.pipe_y[g*COORD_W +: COORD_W] = y_q[g];
  end

  assign bus.score       = score_q;
  assign bus.speed       = speed_q;
  assign bus.score_pulse = pulse_q;

endmodule

// File: tb/tb_pipe_field.sv
// Bench for pipe_field: two instances (16-bit and 4-bit score) against a reference model.
// Expected state is queued as each cycle is driven and compared after the clock edge.
module tb_pipe_field;
  import game_pkg::*;

  localparam int NP = 4;
  localparam int CW = 11;
  localparam int YC = 146;
  localparam int SMAX [2] = '{65535, 15};

  typedef struct packed {
    logic [NP*CW-1:0] px;
    logic [NP*CW-1:0] py;
    logic [15:0]      score;
    logic [2:0]       speed;
    logic             pulse;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_field_if #(.NUM_PIPES(NP), .COORD_W(CW), .SCORE_W(16)) bus_a ();
  pipe_field_if #(.NUM_PIPES(NP), .COORD_W(CW), .SCORE_W(4))  bus_b ();

  pipe_field #(.NUM_PIPES(NP), .COORD_W(CW), .SCORE_W(16)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  pipe_field #(.NUM_PIPES(NP), .COORD_W(CW), .SCORE_W(4))  u_b (.clk(clk), .rst(rst), .bus(bus_b));

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   bird = 100;
  obs_t sb_a[$];
  obs_t sb_b[$];

  int          mx   [2][NP];
  int          my   [2][NP];
  bit          mp   [2][NP];
  int          msc  [2];
  int          mspd [2];
  bit          mpl  [2];
  logic [15:0] mlfsr;

  function automatic int gap(int i);
    logic [31:0] w;
    w = {mlfsr, mlfsr} << ((3 * i) % 16);
    return YC + int'(w[21:16]);
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  task automatic model_step(bit r, bit ft, logic [3:0] gs);
    int xn [NP];
    int hit;
    if (r) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NP; i++) begin
          mx[d][i] = 700 + 250 * i; my[d][i] = YC; mp[d][i] = 1'b0;
        end
        msc[d] = 0; mspd[d] = 1; mpl[d] = 1'b0;
      end
      mlfsr = 16'hACE1;
      return;
    end
    for (int d = 0; d < 2; d++) begin
      mpl[d] = 1'b0;
      if (ft && gs == 4'b0001) begin
        for (int i = 0; i < NP; i++) begin
          mx[d][i] = 700 + 250 * i; my[d][i] = gap(i); mp[d][i] = 1'b0;
        end
        msc[d] = 0; mspd[d] = 1;
      end else if (ft && gs == 4'b0010) begin
        for (int i = 0; i < NP; i++) xn[i] = mx[d][i] - mspd[d];
        hit = 0;
        for (int i = 0; i < NP; i++) begin
          if (xn[i] + 78 <= 0) begin
            mx[d][i] = xn[(i + NP - 1) % NP] + 250; my[d][i] = gap(i); mp[d][i] = 1'b0;
          end else begin
            mx[d][i] = xn[i];
            if (!mp[d][i] && xn[i] + 78 < bird) begin
              mp[d][i] = 1'b1; hit++;
            end
          end
        end
        mspd[d] = 1 + ((msc[d] / 8 > 3) ? 3 : msc[d] / 8);
        msc[d]  = (msc[d] + hit > SMAX[d]) ? SMAX[d] : msc[d] + hit;
        mpl[d]  = (hit > 0);
      end
    end
    mlfsr = lfsr_next(mlfsr);
  endtask

  function automatic obs_t model_obs(int d);
    obs_t o;
    for (int i = 0; i < NP; i++) begin
      o.px[i*CW +: CW] = CW'(mx[d][i]);
      o.py[i*CW +: CW] = CW'(my[d][i]);
    end
    o.score = 16'(msc[d]);
    o.speed = 3'(mspd[d]);
    o.pulse = mpl[d];
    return o;
  endfunction

  function automatic logic [CW-1:0] pxa(int i);
    return bus_a.pipe_x[i*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] pya(int i);
    return bus_a.pipe_y[i*CW +: CW];
  endfunction

  task automatic step(bit r, bit ft, logic [3:0] gs);
    obs_t ea, eb, ga, gb;
    rst = r;
    bus_a.frame_tick = ft;  bus_b.frame_tick = ft;
    bus_a.game_state = gs;  bus_b.game_state = gs;
    bus_a.bird_x = CW'(bird); bus_b.bird_x = CW'(bird);
    model_step(r, ft, gs);
    sb_a.push_back(model_obs(0));
    sb_b.push_back(model_obs(1));
    @(posedge clk);
    #1;
    cyc++;
    ga = {bus_a.pipe_x, bus_a.pipe_y, bus_a.score, bus_a.speed, bus_a.score_pulse};
    gb = {bus_b.pipe_x, bus_b.pipe_y, 12'd0, bus_b.score, bus_b.speed, bus_b.score_pulse};
    ea = sb_a.pop_front();
    eb = sb_b.pop_front();
    checks++;
    if (ga !== ea) begin
      failures++;
      $display("FAIL state_a cyc=%0d got=%h exp=%h", cyc, ga, ea);
    end
    checks++;
    if (gb !== eb) begin
      failures++;
      $display("FAIL state_b cyc=%0d got=%h exp=%h", cyc, gb, eb);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, IN_GAME);
    step(1'b1, 1'b0, IN_GAME);
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (pxa(i) !== CW'(700 + 250 * i)) begin
        failures++; $display("FAIL reset_x%0d got=%0d exp=%0d", i, pxa(i), 700 + 250 * i);
      end
      checks++;
      if (pya(i) !== CW'(YC)) begin
        failures++; $display("FAIL reset_y%0d got=%0d exp=%0d", i, pya(i), YC);
      end
    end
    checks++;
    if (bus_a.score !== 16'd0 || bus_a.speed !== 3'd1 || bus_a.score_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl got score=%0d speed=%0d pulse=%b exp 0/1/0",
               bus_a.score, bus_a.speed, bus_a.score_pulse);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, IN_GAME);
    checks++;
    if (pxa(0) !== CW'(700) || pxa(3) !== CW'(1450)) begin
      failures++; $display("FAIL idle_hold got=%0d,%0d exp=700,1450", pxa(0), pxa(3));
    end
  endtask

  task automatic test_move();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, IN_GAME);
    checks++;
    if (pxa(0) !== CW'(690) || pxa(3) !== CW'(1440)) begin
      failures++; $display("FAIL move10 got=%0d,%0d exp=690,1440", pxa(0), pxa(3));
    end
  endtask

  task automatic test_score_recycle();
    int pulses = 0;
    for (int k = 0; k < 767; k++) begin
      step(1'b0, 1'b1, IN_GAME);
      if (bus_a.score_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pxa(0) !== CW'(-77)) begin
      failures++; $display("FAIL edge_x got=%h exp=%h", pxa(0), CW'(-77));
    end
    step(1'b0, 1'b1, IN_GAME);
    if (bus_a.score_pulse === 1'b1) pulses++;
    checks++;
    if (pxa(0) !== CW'(922)) begin
      failures++; $display("FAIL recycle_x got=%0d exp=922", pxa(0));
    end
    checks++;
    if ($isunknown(pya(0)) || pya(0) < CW'(146) || pya(0) > CW'(209)) begin
      failures++; $display("FAIL recycle_y got=%0d exp 146..209", pya(0));
    end
    checks++;
    if (pulses != 1 || bus_a.score !== 16'd1) begin
      failures++; $display("FAIL single_score got pulses=%0d score=%0d exp 1/1", pulses, bus_a.score);
    end
  endtask

  task automatic test_pause();
    for (int k = 0; k < 50; k++) step(1'b0, 1'b1, PAUSE);
    checks++;
    if (pxa(0) !== CW'(922) || pxa(3) !== CW'(672) || bus_a.score !== 16'd1) begin
      failures++;
      $display("FAIL pause_hold got x0=%0d x3=%0d score=%0d exp 922/672/1", pxa(0), pxa(3), bus_a.score);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, END_SCREEN);
    step(1'b0, 1'b1, 4'b0011);
    step(1'b0, 1'b1, 4'b0000);
    checks++;
    if (pxa(0) !== CW'(922) || bus_a.score_pulse !== 1'b0) begin
      failures++; $display("FAIL hold_other got x0=%0d pulse=%b exp 922/0", pxa(0), bus_a.score_pulse);
    end
  endtask

  task automatic test_speed();
    int  k = 0;
    bit  arm2 = 1'b0;
    bit  arm4 = 1'b0;
    bit  ft;
    int  prev;
    while (msc[0] < 42 && k < 30000) begin
      ft   = (k % 3) != 2;
      prev = msc[0];
      step(1'b0, ft, IN_GAME);
      if (ft && arm2) begin
        arm2 = 1'b0;
        checks++;
        if (bus_a.speed !== 3'd2) begin
          failures++; $display("FAIL speed_at8 got=%0d exp=2", bus_a.speed);
        end
      end
      if (ft && arm4) begin
        arm4 = 1'b0;
        checks++;
        if (bus_a.speed !== 3'd4) begin
          failures++; $display("FAIL speed_at24 got=%0d exp=4", bus_a.speed);
        end
      end
      if (prev < 8 && msc[0] >= 8) arm2 = 1'b1;
      if (prev < 24 && msc[0] >= 24) arm4 = 1'b1;
      k++;
    end
    checks++;
    if (k >= 30000) begin
      failures++; $display("FAIL speed_budget got=%0d frames exp score 42", k);
    end
    checks++;
    if (bus_a.score !== 16'd42 || bus_a.speed !== 3'd4) begin
      failures++; $display("FAIL speed_cap got score=%0d speed=%0d exp 42/4", bus_a.score, bus_a.speed);
    end
    checks++;
    if (bus_b.score !== 4'd15 || bus_b.speed !== 3'd2) begin
      failures++; $display("FAIL saturate got score=%0d speed=%0d exp 15/2", bus_b.score, bus_b.speed);
    end
  endtask

  task automatic test_start_screen();
    step(1'b0, 1'b1, START_SCREEN);
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (pxa(i) !== CW'(700 + 250 * i) || $isunknown(pya(i)) ||
          pya(i) < CW'(146) || pya(i) > CW'(209)) begin
        failures++;
        $display("FAIL reload_p%0d got x=%0d y=%0d exp x=%0d y 146..209", i, pxa(i), pya(i), 700 + 250 * i);
      end
    end
    checks++;
    if (bus_a.score !== 16'd0 || bus_a.speed !== 3'd1 || bus_b.score !== 4'd0) begin
      failures++;
      $display("FAIL reload_ctl got a=%0d/%0d b=%0d exp 0/1 0", bus_a.score, bus_a.speed, bus_b.score);
    end
    step(1'b0, 1'b0, START_SCREEN);
  endtask

  task automatic test_rst_override();
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, IN_GAME);
    step(1'b1, 1'b1, IN_GAME);
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (pxa(i) !== CW'(700 + 250 * i) || pya(i) !== CW'(YC)) begin
        failures++;
        $display("FAIL rst_over_p%0d got x=%0d y=%0d exp x=%0d y=%0d", i, pxa(i), pya(i), 700 + 250 * i, YC);
      end
    end
    checks++;
    if (bus_a.score !== 16'd0 || bus_a.speed !== 3'd1) begin
      failures++; $display("FAIL rst_over_ctl got %0d/%0d exp 0/1", bus_a.score, bus_a.speed);
    end
    step(1'b0, 1'b0, IN_GAME);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_move();
    test_score_recycle();
    test_pause();
    test_speed();
    test_start_screen();
    test_rst_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
